// File: rtl/csc_rgb_pack.sv
// csc_rgb_pack: converts one YUV pixel pair to RGB and packs the
// six bytes into three 16-bit SRAM words written to a frame buffer.
//
// Ports:
//   CLOCK_50_I       clock, rising edge
//   reset            synchronous active-high reset
//   in_valid/ready   pixel-pair handshake (ready only when idle)
//   Y_pair           {even Y, odd Y}
//   U_even, V_even   even chroma, unsigned
//   U_odd, V_odd     interpolated chroma, two's complement
//   SRAM_address     write address, wraps at end of frame
//   SRAM_write_data  packed RGB word
//   SRAM_we_n        active-low write strobe
//   frame_done       pulse during the last word of a frame
module csc_rgb_pack #(
    parameter logic [17:0] RGB_BASE    = 18'd146944,
    parameter int          FRAME_WORDS = 115200
) (
    input  logic        CLOCK_50_I,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] Y_pair,
    input  logic [7:0]  U_even,
    input  logic [7:0]  V_even,
    input  logic [31:0] U_odd,
    input  logic [31:0] V_odd,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    output logic        frame_done
);

    localparam logic [17:0] LAST_ADDR = RGB_BASE + 18'(FRAME_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE, CALC_E, CALC_O, WR0, WR1, WR2
    } state_t;

    state_t state, state_n;

    logic [7:0] y_e, u_e, v_e;
    logic [7:0] y_o, u_o, v_o;
    logic [7:0] r0, g0, b0;
    logic [7:0] r1, g1, b1;

    logic [7:0]         py, pu, pv;
    logic signed [31:0] cy, cu, cv;
    logic signed [31:0] yy, rs, gs, bs;

    logic        wr_now, wr_next;
    logic [17:0] addr_step, addr_d;

    // Interpolated chroma may over/undershoot; saturate to a byte.
    function automatic logic [7:0] clip_in(input logic signed [31:0] v);
        if (v < 0)
            return 8'd0;
        else if (v > 32'sd255)
            return 8'hFF;
        else
            return v[7:0];
    endfunction

    // Channel sums are fixed point with 16 fractional bits.
    function automatic logic [7:0] clip_ch(input logic signed [31:0] s);
        if (s[31])
            return 8'd0;
        else if (s[31:16] > 16'd255)
            return 8'hFF;
        else
            return s[23:16];
    endfunction

    always_ff @(posedge CLOCK_50_I) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (in_valid) state_n = CALC_E;
            CALC_E:  state_n = CALC_O;
            CALC_O:  state_n = WR0;
            WR0:     state_n = WR1;
            WR1:     state_n = WR2;
            WR2:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign in_ready = (state == IDLE);

    assign wr_now  = (state == WR0) || (state == WR1) || (state == WR2);
    assign wr_next = (state_n == WR0) || (state_n == WR1) ||
                     (state_n == WR2);

    // The address register always shows the word being written, so it
    // steps on every edge that leaves a write state.
    assign addr_step = (SRAM_address == LAST_ADDR) ? RGB_BASE
                                                   : SRAM_address + 18'd1;
    assign addr_d    = wr_now ? addr_step : SRAM_address;

    // One pixel datapath shared by the even and odd calculation cycles.
    always_comb begin
        py = y_e;
        pu = u_e;
        pv = v_e;
        if (state == CALC_O) begin
            py = y_o;
            pu = u_o;
            pv = v_o;
        end
        cy = $signed({24'd0, py}) - 32'sd16;
        cu = $signed({24'd0, pu}) - 32'sd128;
        cv = $signed({24'd0, pv}) - 32'sd128;
        yy = 32'sd76284 * cy;
        rs = yy + 32'sd104595 * cv;
        gs = yy - 32'sd25624 * cu - 32'sd53281 * cv;
        bs = yy + 32'sd132251 * cu;
    end

    always_ff @(posedge CLOCK_50_I) begin
        if (reset) begin
            y_e             <= '0;
            u_e             <= '0;
            v_e             <= '0;
            y_o             <= '0;
            u_o             <= '0;
            v_o             <= '0;
            r0              <= '0;
            g0              <= '0;
            b0              <= '0;
            r1              <= '0;
            g1              <= '0;
            b1              <= '0;
            SRAM_address    <= RGB_BASE;
            SRAM_write_data <= '0;
            SRAM_we_n       <= 1'b1;
            frame_done      <= 1'b0;
        end else begin
            if (state == IDLE && in_valid) begin
                y_e <= Y_pair[15:8];
                u_e <= U_even;
                v_e <= V_even;
                y_o <= Y_pair[7:0];
                u_o <= clip_in(U_odd);
                v_o <= clip_in(V_odd);
            end
            if (state == CALC_E) begin
                r0 <= clip_ch(rs);
                g0 <= clip_ch(gs);
                b0 <= clip_ch(bs);
            end
            if (state == CALC_O) begin
                r1 <= clip_ch(rs);
                g1 <= clip_ch(gs);
                b1 <= clip_ch(bs);
            end
            SRAM_address <= addr_d;
            SRAM_we_n    <= ~wr_next;
            frame_done   <= wr_next && (addr_d == LAST_ADDR);
            // Data is loaded on entry so it lines up with the strobe.
            case (state_n)
                WR0:     SRAM_write_data <= {r0, g0};
                WR1:     SRAM_write_data <= {b0, r1};
                WR2:     SRAM_write_data <= {g1, b1};
                default: SRAM_write_data <= SRAM_write_data;
            endcase
        end
    end

endmodule

// File: tb/tb_csc_rgb_pack.sv
// Testbench for csc_rgb_pack: fixed vectors, back-to-back flow,
// reset corner cases and random pairs against a reference model.
module tb_csc_rgb_pack;

    localparam logic [17:0] BASE = 18'd146944;
    localparam int          FW   = 6;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] Y_pair = '0;
    logic [7:0]  U_even = '0;
    logic [7:0]  V_even = '0;
    logic [31:0] U_odd  = '0;
    logic [31:0] V_odd  = '0;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;
    logic        frame_done;

    always #5 clk = ~clk;

    csc_rgb_pack #(
        .RGB_BASE   (BASE),
        .FRAME_WORDS(FW)
    ) dut (
        .CLOCK_50_I     (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .Y_pair         (Y_pair),
        .U_even         (U_even),
        .V_even         (V_even),
        .U_odd          (U_odd),
        .V_odd          (V_odd),
        .SRAM_address   (SRAM_address),
        .SRAM_write_data(SRAM_write_data),
        .SRAM_we_n      (SRAM_we_n),
        .frame_done     (frame_done)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int widx  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [17:0] a;
        logic [15:0] d;
        logic        fd;
        int          c;
    } exp_t;

    exp_t q[$];

    typedef struct {
        logic [15:0] yp;
        logic [7:0]  ue;
        logic [7:0]  ve;
        logic [31:0] uo;
        logic [31:0] vo;
        logic [47:0] w;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on each pixel.
    function automatic int ch(input int s);
        if (s < 0) return 0;
        if (s / 65536 > 255) return 255;
        return s / 65536;
    endfunction

    function automatic int cl(input logic [31:0] v);
        int s;
        s = $signed(v);
        if (s < 0) return 0;
        if (s > 255) return 255;
        return s;
    endfunction

    function automatic void pix(input int yv, input int uv, input int vv,
                                output int r, output int g, output int b);
        int y;
        y = 76284 * (yv - 16);
        r = ch(y + 104595 * (vv - 128));
        g = ch(y - 25624 * (uv - 128) - 53281 * (vv - 128));
        b = ch(y + 132251 * (uv - 128));
    endfunction

    function automatic logic [47:0] model(input logic [15:0] yp,
                                          input logic [7:0] ue,
                                          input logic [7:0] ve,
                                          input logic [31:0] uo,
                                          input logic [31:0] vo);
        int r0, g0, b0, r1, g1, b1;
        pix(int'(yp[15:8]), int'(ue), int'(ve), r0, g0, b0);
        pix(int'(yp[7:0]), cl(uo), cl(vo), r1, g1, b1);
        return {8'(r0), 8'(g0), 8'(b0), 8'(r1), 8'(g1), 8'(b1)};
    endfunction

    // Every write strobe is matched against the expected queue.
    always @(negedge clk) begin
        if (SRAM_we_n === 1'b0) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: addr %0h data %0h",
                         SRAM_address, SRAM_write_data);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (SRAM_address !== e.a || SRAM_write_data !== e.d ||
                    frame_done !== e.fd || cyc != e.c) begin
                    fails++;
                    $display("FAIL write: got a=%0h d=%0h fd=%0b cyc=%0d expected a=%0h d=%0h fd=%0b cyc=%0d",
                             SRAM_address, SRAM_write_data, frame_done, cyc,
                             e.a, e.d, e.fd, e.c);
                end
            end
        end else if (!reset) begin
            tests++;
            if (frame_done !== 1'b0) begin
                fails++;
                $display("FAIL frame_done_idle: got %b expected 0",
                         frame_done);
            end
        end
    end

    task automatic send(input logic [15:0] yp, input logic [7:0] ue,
                        input logic [7:0] ve, input logic [31:0] uo,
                        input logic [31:0] vo, input logic [47:0] w,
                        input int nw, input bit hold, output int hs);
        int n;
        n = 0;
        @(negedge clk);
        Y_pair   = yp;
        U_even   = ue;
        V_even   = ve;
        U_odd    = uo;
        V_odd    = vo;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("handshake_ready", {31'd0, in_ready}, 32'd1);
        hs = cyc + 1;
        for (int k = 0; k < nw; k++) begin
            exp_t e;
            e.a  = BASE + 18'(widx);
            e.d  = w[47 - 16 * k -: 16];
            e.fd = (widx == FW - 1);
            e.c  = hs + 2 + k;
            q.push_back(e);
            widx = (widx + 1) % FW;
        end
        @(posedge clk);
        #1;
        if (!hold) in_valid = 1'b0;
        // Inputs after the handshake must not affect the pair.
        Y_pair = 16'($urandom);
        U_even = 8'($urandom);
        V_even = 8'($urandom);
        U_odd  = $urandom;
        V_odd  = $urandom;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", q.size(), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    vec_t vt[3];

    initial begin
        int hs1, hs2, hs3;
        logic [47:0] w;
        logic [15:0] yp;
        logic [7:0]  ue, ve;
        logic [31:0] uo, vo;

        vt[0] = '{16'h10EB, 8'd128, 8'd128, 32'd128, 32'd128,
                  {16'h0000, 16'h00FE, 16'hFEFE}};
        vt[1] = '{16'h5151, 8'd90, 8'd240, 32'd90, 32'd240,
                  {16'hFE00, 16'h00FE, 16'h0000}};
        vt[2] = '{16'hFFFF, 8'd128, 8'd128, 32'hFFFFFFF0, 32'd300,
                  {16'hFFFF, 16'hFFFF, 16'hE013}};

        repeat (3) @(negedge clk);
        chk("rst_we_n", {31'd0, SRAM_we_n}, 32'd1);
        chk("rst_addr", {14'd0, SRAM_address}, {14'd0, BASE});
        chk("rst_data", {16'd0, SRAM_write_data}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {31'd0, in_ready}, 32'd1);

        // Fixed vectors; nine words wrap the six-word frame.
        for (int i = 0; i < 3; i++) begin
            send(vt[i].yp, vt[i].ue, vt[i].ve, vt[i].uo, vt[i].vo,
                 vt[i].w, 3, 1'b0, hs1);
            if (i == 0) begin
                for (int k = 0; k < 6; k++) begin
                    @(negedge clk);
                    chk("ready_pattern", {31'd0, in_ready},
                        (k == 5) ? 32'd1 : 32'd0);
                end
            end
        end
        drain();

        // Back-to-back pairs with in_valid held high.
        for (int i = 0; i < 3; i++) begin
            yp = 16'($urandom);
            ue = 8'($urandom);
            ve = 8'($urandom);
            uo = 32'($urandom_range(0, 330)) - 32'd40;
            vo = 32'($urandom_range(0, 330)) - 32'd40;
            w  = model(yp, ue, ve, uo, vo);
            if (i == 0) send(yp, ue, ve, uo, vo, w, 3, 1'b1, hs1);
            if (i == 1) send(yp, ue, ve, uo, vo, w, 3, 1'b1, hs2);
            if (i == 2) send(yp, ue, ve, uo, vo, w, 3, 1'b0, hs3);
        end
        chk("b2b_gap1", hs2 - hs1, 32'd6);
        chk("b2b_gap2", hs3 - hs2, 32'd6);
        drain();

        // Reset while the second word is on the bus.
        w = model(16'h8040, 8'd60, 8'd200, 32'd20, 32'd180);
        send(16'h8040, 8'd60, 8'd200, 32'd20, 32'd180, w, 2, 1'b0, hs1);
        do @(negedge clk); while (cyc < hs1 + 3);
        reset = 1'b1;
        @(negedge clk);
        chk("wr1_rst_we_n", {31'd0, SRAM_we_n}, 32'd1);
        chk("wr1_rst_addr", {14'd0, SRAM_address}, {14'd0, BASE});
        chk("wr1_rst_ready", {31'd0, in_ready}, 32'd1);
        reset = 1'b0;
        widx  = 0;
        w = model(16'h3399, 8'd10, 8'd250, 32'd77, 32'hFFFFFF00);
        send(16'h3399, 8'd10, 8'd250, 32'd77, 32'hFFFFFF00, w, 3,
             1'b0, hs1);
        drain();

        // Reset wins over a simultaneous handshake.
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        widx     = 0;
        chk("rst_prio_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_prio_addr", {14'd0, SRAM_address}, {14'd0, BASE});
        repeat (8) @(negedge clk);

        for (int i = 0; i < 20; i++) begin
            yp = 16'($urandom);
            ue = 8'($urandom);
            ve = 8'($urandom);
            uo = ($urandom_range(0, 3) == 0) ? $urandom
                 : 32'($urandom_range(0, 330)) - 32'd40;
            vo = ($urandom_range(0, 3) == 0) ? $urandom
                 : 32'($urandom_range(0, 330)) - 32'd40;
            w  = model(yp, ue, ve, uo, vo);
            send(yp, ue, ve, uo, vo, w, 3, 1'b0, hs1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
